// File: rtl/coalescing_write_buffer.sv
// Store buffer that merges same-word stores into the youngest entry and drains oldest-first.
// Zero-latency combinational drain/lookup views; push stalls only when full and not merging.
module coalescing_write_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid_in,
  input  logic [ADDR_W-1:0] push_addr_in,
  input  logic [DATA_W-1:0] push_data_in,
  input  logic [BE_W-1:0]   push_be_in,
  output logic              push_ready_out,
  output logic              drain_valid_out,
  output logic [ADDR_W-1:0] drain_addr_out,
  output logic [DATA_W-1:0] drain_data_out,
  output logic [BE_W-1:0]   drain_be_out,
  input  logic              drain_ready_in,
  input  logic [ADDR_W-1:0] lookup_addr_in,
  output logic              lookup_hit_out,
  output logic [DATA_W-1:0] lookup_data_out,
  output logic [BE_W-1:0]   lookup_be_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              full_out,
  output logic              empty_out
);

  localparam int OFF_W = $clog2(BE_W);
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << OFF_W;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [BE_W-1:0]   ent_be   [DEPTH];

  logic [PTR_W-1:0]  head, tail, young;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] push_word, lookup_word;
  logic [DATA_W-1:0] byte_mask;
  logic              pop, push, coalesce_hit, alloc, merge;

  assign young       = tail - PTR_W'(1);
  assign push_word   = push_addr_in & WORD_MASK;
  assign lookup_word = lookup_addr_in & WORD_MASK;

  assign count_out = count;
  assign full_out  = (count == CNT_W'(DEPTH));
  assign empty_out = (count == '0);

  assign drain_valid_out = !empty_out;
  assign drain_addr_out  = ent_addr[head];
  assign drain_data_out  = ent_data[head];
  assign drain_be_out    = ent_be[head];

  assign pop = drain_valid_out && drain_ready_in;

  // A lone entry leaving this cycle cannot absorb the store; it must allocate anew.
  assign coalesce_hit = !empty_out && (ent_addr[young] == push_word)
                        && !((count == CNT_W'(1)) && pop);

  assign push_ready_out = !full_out || coalesce_hit;
  assign push  = push_valid_in && push_ready_out;
  assign alloc = push && !coalesce_hit;
  assign merge = push && coalesce_hit;

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      byte_mask[b*8 +: 8] = {8{push_be_in[b]}};
    end
  end

  // Unenabled bytes of a fresh entry are stored as zero so merged data never leaks stale bytes.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail] <= push_word;
      ent_data[tail] <= push_data_in & byte_mask;
      ent_be[tail]   <= push_be_in;
    end else if (merge) begin
      ent_data[young] <= (ent_data[young] & ~byte_mask) | (push_data_in & byte_mask);
      ent_be[young]   <= ent_be[young] | push_be_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)   head <= head + PTR_W'(1);
      if (alloc) tail <= tail + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx             = '0;
    lookup_hit_out  = 1'b0;
    lookup_data_out = '0;
    lookup_be_out   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_addr[idx] == lookup_word)) begin
        lookup_hit_out  = 1'b1;
        lookup_data_out = ent_data[idx];
        lookup_be_out   = ent_be[idx];
      end
    end
  end

endmodule

// File: tb/tb_coalescing_write_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_coalescing_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_be;
  logic        push_ready;
  logic        drain_valid;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_be;
  logic        drain_ready;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [3:0]  lookup_be;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];

  coalescing_write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid_in(push_valid), .push_addr_in(push_addr), .push_data_in(push_data),
    .push_be_in(push_be), .push_ready_out(push_ready),
    .drain_valid_out(drain_valid), .drain_addr_out(drain_addr), .drain_data_out(drain_data),
    .drain_be_out(drain_be), .drain_ready_in(drain_ready),
    .lookup_addr_in(lookup_addr), .lookup_hit_out(lookup_hit), .lookup_data_out(lookup_data),
    .lookup_be_out(lookup_be),
    .count_out(count), .full_out(full), .empty_out(empty)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic dr);
    push_valid  = v;
    push_addr   = a;
    push_data   = d;
    push_be     = be;
    drain_ready = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, a, d, be, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic drain_all();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    lookup_addr = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #2;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (drain_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drain_valid got=%b exp=0", drain_valid); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lookup_hit got=%b exp=0", lookup_hit); end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_in_order_drain();
    push1(32'h100, 32'hAABBCCDD, 4'hF);
    push1(32'h104, 32'h11223344, 4'hF);
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL order_count2 got=%0d exp=2", count); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #1;
    n_checks++; if (drain_valid !== 1'b1 || drain_addr !== 32'h100 || drain_data !== 32'hAABBCCDD)
      begin n_fail++; $display("FAIL order_first got=%b/%h/%h exp=1/100/aabbccdd", drain_valid, drain_addr, drain_data); end
    tick();
    n_checks++; if (drain_addr !== 32'h104 || drain_data !== 32'h11223344 || count !== 3'd1)
      begin n_fail++; $display("FAIL order_second got=%h/%h/%0d exp=104/11223344/1", drain_addr, drain_data, count); end
    tick();
    n_checks++; if (count !== 3'd0 || empty !== 1'b1)
      begin n_fail++; $display("FAIL order_empty got=%0d/%b exp=0/1", count, empty); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_coalesce();
    push1(32'h200, 32'h000000FF, 4'b0001);
    push1(32'h202, 32'h0000EE00, 4'b0010);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL coal_count got=%0d exp=1", count); end
    n_checks++; if (drain_addr !== 32'h200 || drain_data !== 32'h0000EEFF || drain_be !== 4'b0011)
      begin n_fail++; $display("FAIL coal_head got=%h/%h/%b exp=200/0000eeff/0011", drain_addr, drain_data, drain_be); end
    drain_all();
  endtask

  task automatic test_full();
    push1(32'h500, 32'h0A0A0A0A, 4'hF);
    push1(32'h504, 32'h04040404, 4'hF);
    push1(32'h508, 32'h08080808, 4'hF);
    push1(32'h50C, 32'h0C0C0C0C, 4'hF);
    drive(1'b1, 32'h510, 32'hDEADBEEF, 4'hF, 1'b0);
    #1;
    n_checks++; if (full !== 1'b1 || push_ready !== 1'b0)
      begin n_fail++; $display("FAIL full_stall got=%b/%b exp=1/0", full, push_ready); end
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold got=%0d exp=4", count); end
    drive(1'b1, 32'h50C, 32'h0000BEEF, 4'b0011, 1'b0);
    #1;
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL full_merge_ready got=%b exp=1", push_ready); end
    tick();
    lookup_addr = 32'h50C;
    drive(1'b1, 32'h510, 32'hDEADBEEF, 4'hF, 1'b1);
    #1;
    n_checks++; if (count !== 3'd4 || lookup_data !== 32'h0C0CBEEF || lookup_be !== 4'hF)
      begin n_fail++; $display("FAIL full_merge got=%0d/%h/%h exp=4/0c0cbeef/f", count, lookup_data, lookup_be); end
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_stall got=%b exp=0", push_ready); end
    tick();
    n_checks++; if (count !== 3'd3 || drain_addr !== 32'h504)
      begin n_fail++; $display("FAIL full_pop got=%0d/%h exp=3/504", count, drain_addr); end
    drain_all();
  endtask

  task automatic test_lookup();
    push1(32'h300, 32'h00000001, 4'hF);
    push1(32'h304, 32'h00000033, 4'hF);
    push1(32'h300, 32'h00000002, 4'hF);
    lookup_addr = 32'h302;
    #1;
    n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h2)
      begin n_fail++; $display("FAIL lookup_youngest got=%b/%h exp=1/2", lookup_hit, lookup_data); end
    lookup_addr = 32'h308;
    #1;
    n_checks++; if (lookup_hit !== 1'b0 || lookup_data !== 32'h0 || lookup_be !== 4'h0)
      begin n_fail++; $display("FAIL lookup_miss got=%b/%h/%h exp=0/0/0", lookup_hit, lookup_data, lookup_be); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL lookup_count got=%0d exp=3", count); end
    drain_all();
  endtask

  task automatic test_coalesce_vs_pop();
    push1(32'h400, 32'hAAAAAAAA, 4'hF);
    drive(1'b1, 32'h400, 32'h000000BB, 4'b0001, 1'b1);
    #1;
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL cvp_ready got=%b exp=1", push_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #1;
    n_checks++; if (count !== 3'd1 || drain_data !== 32'h000000BB || drain_be !== 4'b0001)
      begin n_fail++; $display("FAIL cvp_new got=%0d/%h/%b exp=1/000000bb/0001", count, drain_data, drain_be); end
    drain_all();
  endtask

  task automatic test_async_reset();
    push1(32'h700, 32'h1, 4'hF);
    push1(32'h704, 32'h2, 4'hF);
    push1(32'h708, 32'h3, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || drain_valid !== 1'b0)
      begin n_fail++; $display("FAIL async_reset got=%0d/%b exp=0/0", count, drain_valid); end
    drain_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    n_checks++; if (drain_valid !== 1'b0 || empty !== 1'b1)
      begin n_fail++; $display("FAIL async_reset_release got=%b/%b exp=0/1", drain_valid, empty); end
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_reset_after got=%0d exp=0", count); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_random();
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic v, dr, e_pop, e_coal, e_rdy, e_hit;
      logic [31:0] a, aw, d, la, e_ld;
      logic [3:0] be, e_lbe;
      int sz;
      ent_t e;
      v  = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 4);
      a  = 32'h600 + ($urandom_range(0, 4) * 4) + $urandom_range(0, 3);
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      la = 32'h600 + ($urandom_range(0, 5) * 4) + $urandom_range(0, 3);
      drive(v, a, d, be, dr);
      lookup_addr = la;
      @(negedge clk);
      sz     = q.size();
      aw     = a & ~32'h3;
      e_pop  = (sz > 0) && dr;
      e_coal = (sz > 0) && (q[sz-1].addr == aw) && !(sz == 1 && e_pop);
      e_rdy  = (sz < 4) || e_coal;
      e_hit = 1'b0; e_ld = 32'h0; e_lbe = 4'h0;
      foreach (q[i]) if (q[i].addr == (la & ~32'h3)) begin e_hit = 1'b1; e_ld = q[i].data; e_lbe = q[i].be; end
      n_checks++; if (push_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, push_ready, e_rdy); end
      n_checks++; if (count !== 3'(sz) || full !== (sz == 4) || empty !== (sz == 0))
        begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d/%b/%b exp=%0d", cyc, count, full, empty, sz); end
      n_checks++; if (drain_valid !== (sz > 0)) begin n_fail++; $display("FAIL rnd_dvalid cyc=%0d got=%b exp=%b", cyc, drain_valid, sz > 0); end
      if (sz > 0) begin
        n_checks++; if (drain_addr !== q[0].addr || drain_data !== q[0].data || drain_be !== q[0].be)
          begin n_fail++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, drain_addr, drain_data, drain_be, q[0].addr, q[0].data, q[0].be); end
      end
      n_checks++; if (lookup_hit !== e_hit || lookup_data !== e_ld || lookup_be !== e_lbe)
        begin n_fail++; $display("FAIL rnd_lookup cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, lookup_hit, lookup_data, lookup_be, e_hit, e_ld, e_lbe); end
      if (v && e_rdy && e_coal) begin
        e = q[sz-1];
        for (int b = 0; b < 4; b++) if (be[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
        e.be = e.be | be;
        q[sz-1] = e;
      end
      if (e_pop) void'(q.pop_front());
      if (v && e_rdy && !e_coal) begin
        e.addr = aw;
        e.data = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
        e.be = be;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_in_order_drain();
    test_coalesce();
    test_full();
    test_lookup();
    test_coalesce_vs_pop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coalescing_write_buffer.md
COALESCING_WRITE_BUFFER -- requirements
Module: coalescing_write_buffer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL provide parameter DATA_W, default 32, data width; a multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL provide parameter DEPTH, default 4, entry count; a power of 2 and >= 2; CNT_W = log2(DEPTH)+1.
REQ-004 SHALL provide ports:
 clk  in  1  clock, rising edge.
 rst_n  in  1  reset, asynchronous, active-low.
 push_valid_in  in  1  store request.
 push_addr_in  in  ADDR_W  store byte address.
 push_data_in  in  DATA_W  store data.
 push_be_in  in  BE_W  byte enables.
 push_ready_out  out  1  store accepted this cycle if valid.
 drain_valid_out  out  1  head entry available to memory.
 drain_addr_out  out  ADDR_W  head address.
 drain_data_out  out  DATA_W  head data.
 drain_be_out  out  BE_W  head byte enables.
 drain_ready_in  in  1  memory accepts head.
 lookup_addr_in  in  ADDR_W  load address for forwarding.
 lookup_hit_out  out  1  matching entry exists.
 lookup_data_out  out  DATA_W  matching entry data.
 lookup_be_out  out  BE_W  matching entry byte enables.
 count_out  out  CNT_W  occupied entries.
 full_out  out  1  count_out == DEPTH.
 empty_out  out  1  count_out == 0.

Function
REQ-005 SHALL store entries in a circular FIFO with head (oldest) and tail (next free) pointers that wrap modulo DEPTH.
REQ-006 SHALL compare addresses on word bits only: [ADDR_W-1 : log2(BE_W)]; the low bits are ignored and are stored as zero.
REQ-007 SHALL define push = push_valid_in && push_ready_out, and pop = drain_valid_out && drain_ready_in.
REQ-008 SHALL assert coalesce_hit when count >= 1, the youngest entry (tail-1) matches push_addr_in, and NOT (count == 1 and pop).
REQ-009 SHALL drive push_ready_out = !full_out || coalesce_hit; it SHALL NOT depend on drain_ready_in except through REQ-008.
REQ-010 On push with coalesce_hit, SHALL overwrite only the bytes of the youngest entry whose push_be_in is set, OR push_be_in into its byte enables, and leave count and tail unchanged.
REQ-011 On push without coalesce_hit, SHALL write the tail entry with addr/data/be and advance tail.
REQ-012 SHALL never coalesce into any entry other than the youngest, so store order to memory is preserved.
REQ-013 SHALL drive drain_valid_out = !empty_out, with drain_* showing the head entry combinationally; pop SHALL advance head.
REQ-014 SHALL hold drain_* stable while drain_valid_out=1 and drain_ready_in=0, except for coalescing when head == youngest (count == 1).
REQ-015 SHALL update count by +1 for an allocating push only, -1 for a pop only, and 0 for both, neither, or a coalescing push with no pop; a coalescing push with a pop gives -1.
REQ-016 Lookup SHALL be combinational over valid entries; the youngest matching entry wins; lookup_hit_out=0 drives lookup_data_out and lookup_be_out to 0.
REQ-017 Lookup SHALL reflect register state only, not a same-cycle push.
REQ-018 push_be_in == 0 with push_valid_in SHALL be accepted per the normal rules, but SHALL not change any data byte.
REQ-019 Full with a non-matching push SHALL hold push_ready_out=0 and leave state unchanged, even if a pop occurs that cycle.

Reset
REQ-020 While rst_n=0, SHALL clear head, tail and count immediately, giving count_out=0, empty_out=1, full_out=0, drain_valid_out=0, push_ready_out=1, lookup_hit_out=0.
REQ-021 Entry storage SHALL NOT require reset; valid qualification SHALL derive from the pointers and count only.
REQ-022 Reset asserted mid-operation SHALL discard all entries, with no drain handshake afterwards.

Verification (DEPTH=4, DATA_W=32)
REQ-023 Push 0x100/0xAABBCCDD/be=1111, then 0x104/0x11223344/1111, drain_ready=1 -> drains in order 0x100 then 0x104; count 2->0; empty_out=1.
REQ-024 drain_ready=0; push 0x200/0x000000FF/be=0001, then 0x202/0x0000EE00/be=0010 -> count stays 1; head 0x200 data 0x0000EEFF be=0011.
REQ-025 drain_ready=0; push 4 distinct addresses, then push a 5th non-matching -> full_out=1, push_ready_out=0; push matching the youngest -> accepted, count=4.
REQ-026 Entries 0x300 (data 1) and 0x300 behind 0x304 (data 2); lookup 0x300 -> hit=1, data=2; lookup 0x308 -> hit=0, data=0.
REQ-027 count=1 at 0x400; push to 0x400 while drain handshake fires -> new entry allocated, count stays 1, next drain shows only the new bytes.
REQ-028 After 3 pushes, assert rst_n=0 asynchronously mid-cycle -> count_out=0, drain_valid_out=0 before the next clock edge.
